branch_update_queue: RTL and testbench

// - In-order queue of in-flight branch predictions, from the fetch-time predict to execute-time resolution.
// - At resolution it emits the registered update packet to the chooser rankers and the predictor tables:

---
 rtl/bp_pkg.sv | 14 +
 rtl/branch_update_queue_if.sv | 42 ++++
 rtl/bp_entry_ram.sv | 23 ++
 rtl/branch_update_queue.sv | 103 ++++++++++
 tb/tb_branch_update_queue.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Types and constants shared by the branch update queue and the predictor tables.
package bp_pkg;
  localparam int BP_PC_WIDTH  = 32;
  localparam int PRED_GSHARE  = 0;
  localparam int PRED_BIMODAL = 1;
  localparam int PRED_LOCAL   = 2;
  localparam int NUM_PREDS    = 3;

  typedef struct packed {
    logic [BP_PC_WIDTH-1:0] pc;
    logic [NUM_PREDS-1:0]   pred;    // component predictions, indexed by PRED_*
    logic                   choice;  // chooser's final prediction
  } bp_entry_t;
endpackage

// File: rtl/branch_update_queue_if.sv
// Fetch-predict, execute-resolve and predictor-update signals of the branch update queue.
interface branch_update_queue_if
  import bp_pkg::*;
#(
  parameter int PC_WIDTH = BP_PC_WIDTH,
  parameter int DEPTH    = 8
);
  logic                         pred_valid;
  logic [PC_WIDTH-1:0]          pred_pc;
  logic                         pred_gshare;
  logic                         pred_bimodal;
  logic                         pred_local;
  logic                         pred_choice;
  logic                         pred_ready;
  logic                         resolve_valid;
  logic [PC_WIDTH-1:0]          resolve_pc;
  logic                         resolve_taken;
  logic                         flush;
  logic                         upd_valid;
  logic [PC_WIDTH-1:0]          upd_pc;
  logic                         upd_outcome;
  logic                         upd_gshare;
  logic                         upd_bimodal;
  logic                         upd_local;
  logic                         mispredict;
  logic                         resolve_err;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output pred_valid, pred_pc, pred_gshare, pred_bimodal, pred_local, pred_choice,
    output resolve_valid, resolve_pc, resolve_taken, flush,
    input  pred_ready, upd_valid, upd_pc, upd_outcome, upd_gshare, upd_bimodal,
    input  upd_local, mispredict, resolve_err, count
  );

  modport slave (
    input  pred_valid, pred_pc, pred_gshare, pred_bimodal, pred_local, pred_choice,
    input  resolve_valid, resolve_pc, resolve_taken, flush,
    output pred_ready, upd_valid, upd_pc, upd_outcome, upd_gshare, upd_bimodal,
    output upd_local, mispredict, resolve_err, count
  );
endinterface

// File: rtl/bp_entry_ram.sv
// In-flight branch entry storage: one write port, asynchronous read of the head entry.
module bp_entry_ram
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  bp_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output bp_entry_t       rdata
);
  // No reset: validity is tracked entirely by the queue's count.
  bp_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches; emits registered predictor updates and
// the mispredict redirect at resolution, squashing wrong-path entries.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PC_WIDTH = BP_PC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_update_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]       head, tail;
  logic [CW-1:0]       count;
  bp_entry_t           wr_ent, head_ent;
  logic                enq, hit, accept, reject, mis, we;

  logic                upd_valid_q, upd_outcome_q, mispredict_q, resolve_err_q;
  logic [PC_WIDTH-1:0] upd_pc_q;
  logic                upd_gshare_q, upd_bimodal_q, upd_local_q;

  always_comb begin
    wr_ent                     = '0;
    wr_ent.pc                  = BP_PC_WIDTH'(bus.pred_pc);
    wr_ent.pred[PRED_GSHARE]   = bus.pred_gshare;
    wr_ent.pred[PRED_BIMODAL]  = bus.pred_bimodal;
    wr_ent.pred[PRED_LOCAL]    = bus.pred_local;
    wr_ent.choice              = bus.pred_choice;
  end

  // Ready depends only on count, so a dequeue in a full cycle cannot admit a new branch.
  assign bus.pred_ready = (count != CW'(DEPTH));
  assign enq    = bus.pred_valid && bus.pred_ready;
  assign hit    = bus.resolve_valid && (count != '0) &&
                  (head_ent.pc == BP_PC_WIDTH'(bus.resolve_pc));
  assign accept = hit && !bus.flush;
  assign reject = bus.resolve_valid && !hit && !bus.flush;
  assign mis    = accept && (bus.resolve_taken != head_ent.choice);
  assign we     = enq && !bus.flush && !mis;

  bp_entry_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (tail),
    .wdata (wr_ent),
    .raddr (head),
    .rdata (head_ent)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush || mis) begin
      // Every entry younger than a mispredicted head is wrong-path.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)    tail <= tail + 1'b1;
      if (accept) head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(accept);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid_q   <= 1'b0;
      upd_outcome_q <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
      upd_pc_q      <= '0;
      upd_gshare_q  <= 1'b0;
      upd_bimodal_q <= 1'b0;
      upd_local_q   <= 1'b0;
    end else begin
      upd_valid_q   <= accept;
      mispredict_q  <= mis;
      resolve_err_q <= reject;
      if (accept) begin
        upd_outcome_q <= bus.resolve_taken;
        upd_pc_q      <= PC_WIDTH'(head_ent.pc);
        upd_gshare_q  <= head_ent.pred[PRED_GSHARE];
        upd_bimodal_q <= head_ent.pred[PRED_BIMODAL];
        upd_local_q   <= head_ent.pred[PRED_LOCAL];
      end
    end
  end

  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_outcome = upd_outcome_q;
  assign bus.upd_gshare  = upd_gshare_q;
  assign bus.upd_bimodal = upd_bimodal_q;
  assign bus.upd_local   = upd_local_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.resolve_err = resolve_err_q;
  assign bus.count       = count;
endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_branch_update_queue;
  localparam int DEPTH = 8;
  localparam int PCW   = 32;

  typedef struct {
    logic [PCW-1:0] pc;
    logic g, b, l, c;
  } m_ent_t;

  typedef struct {
    logic           err;
    logic           mis;
    logic           outcome;
    logic           g, b, l;
    logic [PCW-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  m_ent_t model_q[$];
  exp_t   exp_q[$];

  branch_update_queue_if #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) bus ();

  branch_update_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic clear_inputs();
    bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_gshare = 0; bus.pred_bimodal = 0;
    bus.pred_local = 0; bus.pred_choice = 0; bus.resolve_valid = 0; bus.resolve_pc = '0;
    bus.resolve_taken = 0; bus.flush = 0;
  endtask

  // One clock of stimulus; the model decides what the queue must do with it.
  task automatic step(input logic pv, input logic [PCW-1:0] ppc, input logic g, input logic b,
                      input logic l, input logic c, input logic rv, input logic [PCW-1:0] rpc,
                      input logic rt, input logic fl);
    exp_t   e;
    m_ent_t n;
    bit     take;
    @(negedge clk);
    bus.pred_valid = pv; bus.pred_pc = ppc; bus.pred_gshare = g; bus.pred_bimodal = b;
    bus.pred_local = l; bus.pred_choice = c; bus.resolve_valid = rv; bus.resolve_pc = rpc;
    bus.resolve_taken = rt; bus.flush = fl;
    take = pv && (model_q.size() < DEPTH);
    if (fl) begin
      model_q.delete();
      take = 0;
    end else if (rv) begin
      e = '{err: 0, mis: 0, outcome: 0, g: 0, b: 0, l: 0, pc: '0};
      if (model_q.size() != 0 && model_q[0].pc == rpc) begin
        e.pc = rpc; e.outcome = rt;
        e.g = model_q[0].g; e.b = model_q[0].b; e.l = model_q[0].l;
        e.mis = (rt != model_q[0].c);
        if (e.mis) begin
          model_q.delete();
          take = 0;
        end else begin
          void'(model_q.pop_front());
        end
      end else begin
        e.err = 1;
      end
      exp_q.push_back(e);
    end
    if (take) begin
      n = '{pc: ppc, g: g, b: b, l: l, c: c};
      model_q.push_back(n);
    end
    @(posedge clk); #1;
    chk("count", 64'(bus.count), 64'(model_q.size()));
    chk("pred_ready", 64'(bus.pred_ready), 64'(model_q.size() != DEPTH));
  endtask

  task automatic enq(input logic [PCW-1:0] pc, input logic g, input logic b, input logic l,
                     input logic c);
    step(1, pc, g, b, l, c, 0, '0, 0, 0);
  endtask

  task automatic res(input logic [PCW-1:0] pc, input logic t);
    step(0, '0, 0, 0, 0, 0, 1, pc, t, 0);
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  // Monitor: every update or error pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!reset && (bus.upd_valid || bus.resolve_err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, bus.upd_valid, bus.resolve_err}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.err)
            chk("resolve_err_pkt", {60'd0, bus.upd_valid, bus.resolve_err, bus.mispredict, 1'b0},
                {60'd0, 1'b0, 1'b1, 1'b0, 1'b0});
          else
            chk("upd_pkt", {26'd0, bus.upd_valid, bus.resolve_err, bus.mispredict, bus.upd_outcome,
                            bus.upd_gshare, bus.upd_bimodal, bus.upd_local, bus.upd_pc},
                {26'd0, 1'b1, 1'b0, e.mis, e.outcome, e.g, e.b, e.l, e.pc});
        end
      end
    end
  end

  initial begin
    logic [PCW-1:0] pc;
    logic           hc;
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_ready", 64'(bus.pred_ready), 64'd1);
    chk("rst_pulses", {61'd0, bus.upd_valid, bus.mispredict, bus.resolve_err}, 64'd0);
    @(negedge clk);
    reset = 0;

    // Basic predict / resolve with a correct prediction.
    enq(32'h100, 1, 0, 1, 1);
    res(32'h100, 1);
    idle();

    // Fill to DEPTH, one extra dropped, then drain in order across the wrap.
    for (int i = 0; i < DEPTH; i++) enq(32'h400 + 32'(i * 4), 1'(i), 1'(i >> 1), 1'(i >> 2), 1'(i % 3 == 0));
    enq(32'h4F0, 1, 1, 1, 1);
    for (int i = 0; i < DEPTH; i++) begin
      hc = model_q[0].c;
      res(32'h400 + 32'(i * 4), hc);
    end
    idle();

    // Mispredict squashes younger entries.
    enq(32'h200, 0, 1, 0, 1);
    enq(32'h204, 1, 1, 0, 0);
    enq(32'h208, 0, 0, 1, 1);
    res(32'h200, 0);
    res(32'h204, 0);
    idle();

    // Rejected resolves: empty queue, then PC mismatch.
    res(32'h300, 1);
    enq(32'h304, 1, 0, 0, 1);
    res(32'h300, 1);
    res(32'h304, 1);
    idle();

    // Flush beats simultaneous resolve and enqueue.
    enq(32'h500, 0, 0, 0, 0);
    enq(32'h504, 1, 1, 1, 1);
    enq(32'h508, 0, 1, 0, 1);
    step(1, 32'h50C, 1, 1, 1, 1, 1, 32'h500, 0, 1);
    idle();

    // Asynchronous reset mid-cycle with an update pulse in flight.
    for (int i = 0; i < 6; i++) enq(32'h600 + 32'(i * 4), 1, 0, 1, 0);
    res(32'h600, 0);
    #2 reset = 1;
    #1;
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_ready", 64'(bus.pred_ready), 64'd1);
    chk("midrst_upd_valid", 64'(bus.upd_valid), 64'd0);
    clear_inputs();
    model_q.delete();
    @(negedge clk);
    reset = 0;
    enq(32'h700, 1, 1, 0, 1);
    res(32'h700, 1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      logic pv, rv, fl, rt, c;
      logic [PCW-1:0] rpc;
      pv = ($urandom % 3) != 0;
      rv = ($urandom % 2) != 0;
      fl = ($urandom % 25) == 0;
      c  = 1'($urandom);
      pc = {14'd0, 16'($urandom), 2'b00};
      if (model_q.size() != 0 && ($urandom % 8) != 0) begin
        rpc = model_q[0].pc;
        rt  = (($urandom % 5) == 0) ? !model_q[0].c : model_q[0].c;
      end else begin
        rpc = {14'd0, 16'($urandom), 2'b00};
        rt  = 1'($urandom);
      end
      step(pv, pc, 1'($urandom), 1'($urandom), 1'($urandom), c, rv, rpc, rt, fl);
    end
    clear_inputs();
    repeat (3) idle();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
